// File: rtl/branch_predict_resolve.sv
// branch_predict_resolve: RV32I branch resolution with a 2-bit counter BHT and saturating statistics
module branch_predict_resolve #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int PC_LSB      = 2,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  pred_pc,
    output logic             pred_taken,
    input  logic             res_valid,
    input  logic [XLEN-1:0]  res_pc,
    input  logic [2:0]       res_funct3,
    input  logic [XLEN-1:0]  res_rs1,
    input  logic [XLEN-1:0]  res_rs2,
    input  logic             res_pred_taken,
    output logic             out_valid,
    output logic             out_taken,
    output logic             out_mispredict,
    output logic             out_illegal,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mp_cnt
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]       bht [BHT_ENTRIES];
    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] res_idx;
    logic             eq;
    logic             lt_s;
    logic             lt_u;
    logic             cond;
    logic             legal;
    logic             taken;
    logic             mispredict;
    logic             upd;
    logic [1:0]       cur;
    logic [1:0]       nxt;
    logic             unused_pc_bits;

    assign pred_idx       = pred_pc[PC_LSB +: IDX_W];
    assign res_idx        = res_pc[PC_LSB +: IDX_W];
    assign pred_taken     = bht[pred_idx][1];
    assign unused_pc_bits = ^{pred_pc, res_pc};

    // Branch condition, legality and the saturated next value of the indexed counter
    always_comb begin
        eq         = res_rs1 == res_rs2;
        lt_s       = $signed(res_rs1) < $signed(res_rs2);
        lt_u       = res_rs1 < res_rs2;
        legal      = res_funct3[2:1] != 2'b01;
        cond       = res_funct3[2] ? (res_funct3[1] ? lt_u : lt_s) : eq;
        taken      = legal && (cond ^ res_funct3[0]);
        mispredict = legal && (taken != res_pred_taken);
        upd        = res_valid && legal;
        cur        = bht[res_idx];
        nxt        = taken ? ((cur == 2'b11) ? cur : cur + 2'd1)
                           : ((cur == 2'b00) ? cur : cur - 2'd1);
    end

    // Counter table: every entry reset to weak-not-taken, one entry trained per legal branch
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
        end else if (upd) begin
            bht[res_idx] <= nxt;
        end
    end

    // Registered resolution result, all flags forced low on idle cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            out_taken      <= 1'b0;
            out_mispredict <= 1'b0;
            out_illegal    <= 1'b0;
        end else begin
            out_valid      <= res_valid;
            out_taken      <= res_valid && taken;
            out_mispredict <= res_valid && mispredict;
            out_illegal    <= res_valid && !legal;
        end
    end

    // Saturating statistics; a clear wins over a same-cycle increment
    always_ff @(posedge clk) begin
        if (!rst_n || stat_clr) begin
            br_cnt <= '0;
            mp_cnt <= '0;
        end else if (upd) begin
            if (~&br_cnt) br_cnt <= br_cnt + CNT_W'(1);
            if (mispredict && ~&mp_cnt) mp_cnt <= mp_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_branch_predict_resolve.sv
// tb_branch_predict_resolve: scoreboard bench for branch_predict_resolve
module tb_branch_predict_resolve;
    localparam int XLEN = 32;
    localparam int BHT  = 64;
    localparam int CW   = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [XLEN-1:0] pred_pc = '0;
    logic            pred_taken;
    logic            res_valid = 1'b0;
    logic [XLEN-1:0] res_pc = '0;
    logic [2:0]      res_funct3 = '0;
    logic [XLEN-1:0] res_rs1 = '0;
    logic [XLEN-1:0] res_rs2 = '0;
    logic            res_pred_taken = 1'b0;
    logic            out_valid;
    logic            out_taken;
    logic            out_mispredict;
    logic            out_illegal;
    logic            stat_clr = 1'b0;
    logic [CW-1:0]   br_cnt;
    logic [CW-1:0]   mp_cnt;

    int         checks = 0;
    int         errors = 0;
    logic [2:0] sb[$];
    logic [2:0] exp_out;
    logic [1:0] mdl[BHT];
    logic [CW-1:0] mdl_br;
    logic [CW-1:0] mdl_mp;

    always #5 clk = ~clk;

    branch_predict_resolve #(.XLEN(XLEN), .BHT_ENTRIES(BHT), .PC_LSB(2), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .res_valid(res_valid), .res_pc(res_pc), .res_funct3(res_funct3),
        .res_rs1(res_rs1), .res_rs2(res_rs2), .res_pred_taken(res_pred_taken),
        .out_valid(out_valid), .out_taken(out_taken), .out_mispredict(out_mispredict),
        .out_illegal(out_illegal), .stat_clr(stat_clr), .br_cnt(br_cnt), .mp_cnt(mp_cnt)
    );

    function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    always @(negedge clk) begin
        checks++;
        if (out_valid) begin
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out_valid got 1 want 0");
            end else begin
                exp_out = sb.pop_front();
                if ({out_taken, out_mispredict, out_illegal} !== exp_out) begin
                    errors++;
                    $display("FAIL result {taken,mp,ill} got %b want %b", {out_taken, out_mispredict, out_illegal}, exp_out);
                end
            end
        end else if ({out_taken, out_mispredict, out_illegal} !== 3'b000) begin
            errors++;
            $display("FAIL idle_outputs got %b want 000", {out_taken, out_mispredict, out_illegal});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic idle();
        res_valid = 1'b0;
        stat_clr  = 1'b0;
        @(negedge clk);
    endtask

    task automatic resolve(input logic [31:0] pc, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic pt, input logic clr);
        logic       legal;
        logic       tk;
        logic [5:0] idx;
        legal = f3[2:1] != 2'b01;
        tk    = legal && ref_taken(f3, a, b);
        idx   = pc[7:2];
        sb.push_back({tk, legal && (tk != pt), !legal});
        res_valid = 1'b1; res_pc = pc; res_funct3 = f3; res_rs1 = a; res_rs2 = b;
        res_pred_taken = pt; stat_clr = clr; pred_pc = pc;
        #1;
        checks++;
        if (pred_taken !== mdl[idx][1]) begin
            errors++;
            $display("FAIL pre_update_pred pc=%h got %b want %b", pc, pred_taken, mdl[idx][1]);
        end
        if (legal) mdl[idx] = tk ? ((mdl[idx] == 2'b11) ? 2'b11 : mdl[idx] + 2'd1)
                                 : ((mdl[idx] == 2'b00) ? 2'b00 : mdl[idx] - 2'd1);
        if (clr) begin
            mdl_br = '0;
            mdl_mp = '0;
        end else if (legal) begin
            if (mdl_br != '1) mdl_br++;
            if (tk != pt && mdl_mp != '1) mdl_mp++;
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || br_cnt !== mdl_br || mp_cnt !== mdl_mp) begin
            errors++;
            $display("FAIL post_resolve valid/br/mp got %b/%0d/%0d want 1/%0d/%0d", out_valid, br_cnt, mp_cnt, mdl_br, mdl_mp);
        end
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        res_valid = 1'b0;
        stat_clr = 1'b0;
        for (int i = 0; i < BHT; i++) mdl[i] = 2'b01;
        mdl_br = '0;
        mdl_mp = '0;
        checks++;
        if (out_valid !== 1'b0 || br_cnt !== '0 || mp_cnt !== '0) begin
            errors++;
            $display("FAIL reset_state valid/br/mp got %b/%0d/%0d want 0/0/0", out_valid, br_cnt, mp_cnt);
        end
    endtask

    task automatic test_reset();
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            pred_pc = 32'h100 + 32'(i * 12);
            #1;
            checks++;
            if (pred_taken !== 1'b0) begin
                errors++;
                $display("FAIL reset_pred pc=%h got %b want 0", pred_pc, pred_taken);
            end
        end
        idle();
    endtask

    task automatic test_beq();
        resolve(32'h100, 3'b000, 32'd5, 32'd5, 1'b0, 1'b0);
        checks++;
        if (out_taken !== 1'b1 || out_mispredict !== 1'b1 || br_cnt !== 4'd1 || mp_cnt !== 4'd1) begin
            errors++;
            $display("FAIL beq tk/mp/br/mpc got %b/%b/%0d/%0d want 1/1/1/1", out_taken, out_mispredict, br_cnt, mp_cnt);
        end
        idle();
        pred_pc = 32'h100;
        #1;
        checks++;
        if (pred_taken !== 1'b1) begin
            errors++;
            $display("FAIL beq_trained_pred got %b want 1", pred_taken);
        end
    endtask

    task automatic test_signed();
        logic [2:0] f3s[5] = '{3'b100, 3'b110, 3'b111, 3'b101, 3'b001};
        logic       want[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            resolve(32'h200 + 32'(i * 4), f3s[i], 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
            checks++;
            if (out_taken !== want[i]) begin
                errors++;
                $display("FAIL signed_cmp f3=%b got %b want %b", f3s[i], out_taken, want[i]);
            end
        end
        idle();
    endtask

    task automatic test_saturation();
        logic [31:0] pcs[3] = '{32'h40, 32'h140, 32'h40};
        logic        want[3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) resolve(32'h40, 3'b000, 32'd7, 32'd7, 1'b1, 1'b0);
        resolve(32'h40, 3'b001, 32'd7, 32'd7, 1'b1, 1'b0);
        idle();
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                resolve(32'h40, 3'b001, 32'd7, 32'd7, 1'b1, 1'b0);
                idle();
            end
            pred_pc = pcs[i];
            #1;
            checks++;
            if (pred_taken !== want[i]) begin
                errors++;
                $display("FAIL sat_pred pc=%h got %b want %b", pcs[i], pred_taken, want[i]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [CW-1:0] br_before;
        br_before = br_cnt;
        resolve(32'h40, 3'b010, 32'd3, 32'd3, 1'b1, 1'b0);
        checks++;
        if (out_illegal !== 1'b1 || out_taken !== 1'b0 || out_mispredict !== 1'b0 || br_cnt !== br_before) begin
            errors++;
            $display("FAIL illegal ill/tk/mp/br got %b/%b/%b/%0d want 1/0/0/%0d", out_illegal, out_taken, out_mispredict, br_cnt, br_before);
        end
        resolve(32'h40, 3'b011, 32'd3, 32'd3, 1'b0, 1'b0);
        idle();
        pred_pc = 32'h40;
        #1;
        checks++;
        if (pred_taken !== 1'b0) begin
            errors++;
            $display("FAIL illegal_table got %b want 0", pred_taken);
        end
    endtask

    task automatic test_stats();
        for (int i = 0; i < 20; i++)
            resolve({22'd0, 8'($urandom_range(0, 255)), 2'b00}, 3'b000, 32'(i), 32'(i), 1'b0, 1'b0);
        checks++;
        if (br_cnt !== 4'hF || mp_cnt !== 4'hF) begin
            errors++;
            $display("FAIL stat_saturate br/mp got %0d/%0d want 15/15", br_cnt, mp_cnt);
        end
        resolve(32'h80, 3'b000, 32'd1, 32'd1, 1'b0, 1'b1);
        checks++;
        if (br_cnt !== 4'd0 || mp_cnt !== 4'd0) begin
            errors++;
            $display("FAIL stat_clear br/mp got %0d/%0d want 0/0", br_cnt, mp_cnt);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 60; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 2) == 0) ? a : 32'($urandom);
            resolve({22'd0, 8'($urandom_range(0, 255)), 2'b00}, 3'($urandom_range(0, 7)), a, b,
                    1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
        end
        idle();
    endtask

    task automatic test_reset_midstream();
        logic [31:0] pcs[3] = '{32'h100, 32'h40, 32'h140};
        resolve(32'h40, 3'b000, 32'd1, 32'd1, 1'b0, 1'b0);
        resolve(32'h40, 3'b000, 32'd1, 32'd1, 1'b0, 1'b0);
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            pred_pc = pcs[i];
            #1;
            checks++;
            if (pred_taken !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_pred pc=%h got %b want 0", pcs[i], pred_taken);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_beq();
        test_signed();
        test_saturation();
        test_illegal();
        test_stats();
        test_back_to_back();
        test_reset_midstream();
        idle();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_predict_resolve.md
# branch_predict_resolve

Parametrised branch unit for the RV32I core: resolves conditional branches by comparing rs1/rs2 according to funct3, and keeps a direct-mapped table of 2-bit saturating counters that supplies a taken/not-taken prediction to fetch. Each resolved branch updates the table. The unit reports, registered, the actual outcome and whether the fetch-time prediction was wrong. Saturating statistics counters track resolved branches and mispredicts.

## Interface
Parameters:
- XLEN, 32, operand and PC width
- BHT_ENTRIES, 64, counter-table depth; power of 2, >= 2
- PC_LSB, 2, lowest PC bit used for the table index
- CNT_W, 32, width of each statistics counter

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  synchronous, active-low reset
- pred_pc  in  XLEN  PC of the instruction in fetch
- pred_taken  out  1  combinational prediction: MSB of counter[idx(pred_pc)]
- res_valid  in  1  a conditional branch is resolving this cycle
- res_pc  in  XLEN  PC of the resolving branch
- res_funct3  in  3  branch funct3
- res_rs1, res_rs2  in  XLEN  operands
- res_pred_taken  in  1  prediction that fetch used for this branch
- out_valid  out  1  registered; res_valid delayed by one cycle
- out_taken  out  1  registered actual outcome
- out_mispredict  out  1  registered: out_taken != res_pred_taken
- out_illegal  out  1  registered: funct3 is 010 or 011
- stat_clr  in  1  clears both statistics counters
- br_cnt  out  CNT_W  resolved legal branches, saturating
- mp_cnt  out  CNT_W  mispredicts, saturating

## Operation
- Index: idx(pc) = pc[PC_LSB +: log2(BHT_ENTRIES)]. The upper PC bits are ignored, so aliasing is allowed.
- Condition by funct3 (taken = cond ^ funct3[0]):
  - 000/001: cond = (rs1 == rs2)
  - 100/101: cond = signed rs1 < rs2
  - 110/111: cond = unsigned rs1 < rs2
- Illegal funct3 (010, 011):
  - out_taken = 0, out_mispredict = 0, out_illegal = 1
  - no table update, no counter increment
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Counter update on a legal res_valid:
  - taken: increment, saturating at 11
  - not taken: decrement, saturating at 00
- Statistics, on a legal res_valid:
  - br_cnt increments
  - mp_cnt increments if mispredicted
  - both hold at all-ones (no wrap)
- stat_clr takes priority over an increment in the same cycle; the result is 0.
- When res_valid = 0: out_valid = 0, and out_taken, out_mispredict, out_illegal are driven to 0.

## Timing
- Reset (rst_n low at a rising edge):
  - out_valid, out_taken, out_mispredict, out_illegal, br_cnt, mp_cnt all = 0
  - every table counter = 01 (weak-NT), so pred_taken = 0 after reset
- Resolution latency: 1 cycle. Inputs sampled at edge N appear on out_* after edge N.
- Throughput: one branch per cycle, no backpressure.
- Table write takes effect at the clock edge. A pred_pc read of an index being updated in the same cycle returns the pre-update value; the new value is visible from the next cycle.
- Back-to-back resolutions to the same index on consecutive cycles each see the previous cycle's update, so the counter steps by one per cycle.
- Reset asserted mid-stream: any in-flight result is discarded. Cycle after reset shows out_valid = 0 and the table at 01.
- pred_taken is purely combinational from pred_pc and table state; there is no path from the res_* inputs into it within the same cycle.

## Test plan
- Reset, then pred_pc = 0x100 -> pred_taken = 0. Resolve beq at pc 0x100 with rs1 = rs2 = 5 and res_pred_taken = 0 -> next cycle out_taken = 1, out_mispredict = 1, br_cnt = 1, mp_cnt = 1. Following cycle pred_taken(0x100) = 1.
- Signed vs unsigned with rs1 = 0xFFFFFFFF, rs2 = 1:
  - blt (100) -> out_taken = 1
  - bltu (110) -> out_taken = 0
  - bgeu (111) -> out_taken = 1
- Saturation: four consecutive taken branches at pc 0x40 -> counter is 11. One not-taken -> 10, so pred_taken is still 1. Aliasing: pc 0x40 + 4*BHT_ENTRIES reads the same entry.
- Illegal funct3 = 010 with res_valid = 1 -> out_valid = 1, out_illegal = 1, out_taken = 0; br_cnt unchanged; table unchanged.
- Counter saturation and clear (CNT_W = 4):
  - 20 legal mispredicts -> br_cnt = mp_cnt = 15
  - stat_clr and res_valid in the same cycle -> both counters = 0
- Reset asserted on the cycle after a res_valid -> out_valid = 0 and all counters = 0. pred_taken = 0 for every trained index.
